time_set_controller: RTL and testbench

Sequences manual time-setting for the wall-clock timekeeping datapath. It turns debounced MODE/UP button levels into single-cycle increment commands for the hour and minute registers. It freezes seconds counting while a field is being set and drives a per-digit blank mask so the field being edited blinks on the seven-segment driver. It sits between the Debounce instances and the time registers / SS_Driver.

---
 rtl/time_set_controller_pkg.sv | 29 ++
 rtl/time_set_controller_key_repeat.sv | 78 +++++++
 rtl/time_set_controller.sv | 160 ++++++++++++++++
 tb/tb_time_set_controller.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/time_set_controller_pkg.sv
// rtl/time_set_controller_pkg.sv - shared types and constants for the time-set controller
//
// Purpose: state encoding and seven-segment digit blank masks used by the
//          time-set controller and its sub-module.
// Contents:
//   state_t     RUN / SET_HOUR / SET_MIN (encoding 3 is illegal)
//   MASK_*      digit blank enables {hours2, hours1, mins2, mins1}
//   field_mask  blank mask for the field edited in a given state
package time_set_controller_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } state_t;

  localparam logic [3:0] MASK_HOURS = 4'b1100;
  localparam logic [3:0] MASK_MINS  = 4'b0011;
  localparam logic [3:0] MASK_NONE  = 4'b0000;

  function automatic logic [3:0] field_mask(input state_t s);
    logic [3:0] m;
    m = MASK_NONE;
    if (s == SET_HOUR) m = MASK_HOURS;
    if (s == SET_MIN)  m = MASK_MINS;
    return m;
  endfunction

endpackage

// File: rtl/time_set_controller_key_repeat.sv
// rtl/time_set_controller_key_repeat.sv - UP button edge detect, arm flag and auto-repeat
//
// Purpose: turns a debounced button level into step requests: one on the
//          armed rising edge, then auto-repeat after a hold delay at a fixed rate.
// Ports:
//   CLK100MHZ  in   system clock
//   RESET_N    in   asynchronous active-low reset
//   btn        in   debounced button level
//   enable     in   1 = steps allowed (a set state is active)
//   disarm     in   1 = a state change happens this cycle; suppress and disarm
//   step       out  combinational step request for the sampling cycle
module key_repeat #(
  parameter int CNT_W               = 30,
  parameter int REPEAT_DELAY_CYCLES = 50_000_000,
  parameter int REPEAT_RATE_CYCLES  = 10_000_000
) (
  input  logic CLK100MHZ,
  input  logic RESET_N,
  input  logic btn,
  input  logic enable,
  input  logic disarm,
  output logic step
);

  localparam logic [CNT_W-1:0] DELAY_C = CNT_W'(REPEAT_DELAY_CYCLES);
  localparam logic [CNT_W-1:0] RATE_C  = CNT_W'(REPEAT_RATE_CYCLES);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic             btn_prev;
  logic             up_armed;
  logic             held;       // current press produced the initial step
  logic             repeating;  // first repeat already issued; use the rate period
  logic [CNT_W-1:0] rpt_cnt;    // cycles since the last step of this press

  logic rise;
  logic first_step;
  logic rpt_step;

  assign rise       = btn & ~btn_prev;
  assign first_step = enable & ~disarm & rise & up_armed;
  assign rpt_step   = enable & ~disarm & held & btn &
                      (rpt_cnt == (repeating ? RATE_C : DELAY_C));
  assign step       = first_step | rpt_step;

  always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      btn_prev  <= 1'b0;
      up_armed  <= 1'b0;
      held      <= 1'b0;
      repeating <= 1'b0;
      rpt_cnt   <= '0;
    end else begin
      btn_prev <= btn;

      // A level held across a state change must be released before it counts.
      if (disarm)
        up_armed <= 1'b0;
      else if (!btn)
        up_armed <= 1'b1;

      if (!enable || disarm || !btn) begin
        held      <= 1'b0;
        repeating <= 1'b0;
        rpt_cnt   <= '0;
      end else if (first_step) begin
        held      <= 1'b1;
        repeating <= 1'b0;
        rpt_cnt   <= ONE_C;
      end else if (rpt_step) begin
        repeating <= 1'b1;
        rpt_cnt   <= ONE_C;
      end else if (held) begin
        rpt_cnt <= rpt_cnt + ONE_C;
      end
    end
  end

endmodule

// File: rtl/time_set_controller.sv
// rtl/time_set_controller.sv - manual time-setting sequencer for the wall clock
//
// Purpose: steps RUN -> SET_HOUR -> SET_MIN -> RUN on MODE edges, issues
//          hour/minute increment pulses from the UP button (with auto-repeat),
//          freezes seconds while setting, blinks the edited field and falls
//          back to RUN after an idle timeout.
// Ports:
//   CLK100MHZ   in   system clock, all state on rising edge
//   RESET_N     in   asynchronous active-low reset
//   MODE_BTN    in   debounced mode button level
//   UP_BTN      in   debounced increment button level
//   INC_HOUR    out  one-cycle pulse: hours +1
//   INC_MIN     out  one-cycle pulse: minutes +1
//   CLR_SECS    out  one-cycle pulse: zero seconds (on exit to RUN)
//   RUN_EN      out  1 = seconds counting
//   BLANK_MASK  out  digit blanks {hours2, hours1, mins2, mins1}
//   MODE        out  current state encoding
module time_set_controller
  import time_set_controller_pkg::*;
#(
  parameter int BLINK_HALF_CYCLES   = 25_000_000,
  parameter int REPEAT_DELAY_CYCLES = 50_000_000,
  parameter int REPEAT_RATE_CYCLES  = 10_000_000,
  parameter int TIMEOUT_CYCLES      = 1_000_000_000,
  parameter int CNT_W               = 30
) (
  input  logic       CLK100MHZ,
  input  logic       RESET_N,
  input  logic       MODE_BTN,
  input  logic       UP_BTN,
  output logic       INC_HOUR,
  output logic       INC_MIN,
  output logic       CLR_SECS,
  output logic       RUN_EN,
  output logic [3:0] BLANK_MASK,
  output logic [1:0] MODE
);

  localparam logic [CNT_W-1:0] BLINK_LAST   = CNT_W'(BLINK_HALF_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE_C        = CNT_W'(1);

  state_t           state;
  logic             mode_prev;
  logic             phase;      // 1 = edited field blanked
  logic [CNT_W-1:0] blink_cnt;
  logic [CNT_W-1:0] idle_cnt;

  logic mode_rise;
  logic in_set;
  logic illegal;
  logic timeout_hit;
  logic state_chg;
  logic up_step;

  assign mode_rise   = MODE_BTN & ~mode_prev;
  assign in_set      = (state == SET_HOUR) || (state == SET_MIN);
  assign illegal     = !(state inside {RUN, SET_HOUR, SET_MIN});
  assign timeout_hit = in_set && !UP_BTN && (idle_cnt == TIMEOUT_LAST);
  // Every MODE edge, a timeout and illegal-state recovery all change state.
  assign state_chg   = mode_rise | timeout_hit | illegal;

  key_repeat #(
    .CNT_W               (CNT_W),
    .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
    .REPEAT_RATE_CYCLES  (REPEAT_RATE_CYCLES)
  ) u_key_repeat (
    .CLK100MHZ (CLK100MHZ),
    .RESET_N   (RESET_N),
    .btn       (UP_BTN),
    .enable    (in_set),
    .disarm    (state_chg),
    .step      (up_step)
  );

  // State machine and its registered outputs.
  always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= RUN;
      mode_prev <= 1'b0;
      MODE      <= RUN;
      RUN_EN    <= 1'b1;
      CLR_SECS  <= 1'b0;
      INC_HOUR  <= 1'b0;
      INC_MIN   <= 1'b0;
    end else begin
      mode_prev <= MODE_BTN;
      CLR_SECS  <= 1'b0;
      // up_step is already suppressed in state-change cycles.
      INC_HOUR  <= up_step && (state == SET_HOUR);
      INC_MIN   <= up_step && (state == SET_MIN);

      case (state)
        RUN: begin
          if (mode_rise) begin
            state  <= SET_HOUR;
            MODE   <= SET_HOUR;
            RUN_EN <= 1'b0;
          end
        end
        SET_HOUR: begin
          if (mode_rise) begin
            state <= SET_MIN;
            MODE  <= SET_MIN;
          end else if (timeout_hit) begin
            state    <= RUN;
            MODE     <= RUN;
            RUN_EN   <= 1'b1;
            CLR_SECS <= 1'b1;
          end
        end
        SET_MIN: begin
          if (mode_rise || timeout_hit) begin
            state    <= RUN;
            MODE     <= RUN;
            RUN_EN   <= 1'b1;
            CLR_SECS <= 1'b1;
          end
        end
        default: begin
          state  <= RUN;
          MODE   <= RUN;
          RUN_EN <= 1'b1;
        end
      endcase
    end
  end

  // Blink generator: restarts visible on every state entry and while UP is
  // held, so the digit being changed stays readable.
  always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      blink_cnt  <= '0;
      phase      <= 1'b0;
      BLANK_MASK <= MASK_NONE;
    end else if (!in_set || state_chg || UP_BTN) begin
      blink_cnt  <= '0;
      phase      <= 1'b0;
      BLANK_MASK <= MASK_NONE;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt  <= '0;
      phase      <= ~phase;
      BLANK_MASK <= phase ? MASK_NONE : field_mask(state);
    end else begin
      blink_cnt  <= blink_cnt + ONE_C;
      BLANK_MASK <= phase ? field_mask(state) : MASK_NONE;
    end
  end

  // Idle timeout: any UP activity or MODE edge restarts the count.
  always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
    if (!RESET_N)
      idle_cnt <= '0;
    else if (!in_set || state_chg || UP_BTN)
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + ONE_C;
  end

endmodule

// File: tb/tb_time_set_controller.sv
// tb/tb_time_set_controller.sv - self-checking bench for time_set_controller
module tb_time_set_controller;

  logic       CLK100MHZ = 1'b0;
  logic       RESET_N   = 1'b0;
  logic       MODE_BTN  = 1'b0;
  logic       UP_BTN    = 1'b0;
  logic       INC_HOUR, INC_MIN, CLR_SECS, RUN_EN;
  logic [3:0] BLANK_MASK;
  logic [1:0] MODE;

  time_set_controller #(
    .BLINK_HALF_CYCLES   (4),
    .REPEAT_DELAY_CYCLES (10),
    .REPEAT_RATE_CYCLES  (3),
    .TIMEOUT_CYCLES      (50),
    .CNT_W               (30)
  ) dut (
    .CLK100MHZ  (CLK100MHZ),
    .RESET_N    (RESET_N),
    .MODE_BTN   (MODE_BTN),
    .UP_BTN     (UP_BTN),
    .INC_HOUR   (INC_HOUR),
    .INC_MIN    (INC_MIN),
    .CLR_SECS   (CLR_SECS),
    .RUN_EN     (RUN_EN),
    .BLANK_MASK (BLANK_MASK),
    .MODE       (MODE)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  logic [9:0] outs;
  assign outs = {MODE, INC_HOUR, INC_MIN, CLR_SECS, RUN_EN, BLANK_MASK};

  typedef struct {
    logic       mode;
    logic       up;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[13];
  int   checks = 0;
  int   passes = 0;

  function automatic logic [9:0] pk(input logic [1:0] m, input logic ih, input logic im,
                                    input logic clr, input logic run, input logic [3:0] mask);
    return {m, ih, im, clr, run, mask};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic do_reset();
    RESET_N  = 1'b0;
    MODE_BTN = 1'b0;
    UP_BTN   = 1'b0;
    tick();
    tick();
    RESET_N = 1'b1;
  endtask

  task automatic press_mode();
    MODE_BTN = 1'b1;
    tick();
    MODE_BTN = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int npulse;
    int nbad;
    int n;
    logic [3:0] em;

    vecs[0]  = '{1'b0, 1'b0, pk(2'd0, 0, 0, 0, 1, 4'b0000)};
    vecs[1]  = '{1'b0, 1'b1, pk(2'd0, 0, 0, 0, 1, 4'b0000)};
    vecs[2]  = '{1'b0, 1'b0, pk(2'd0, 0, 0, 0, 1, 4'b0000)};
    vecs[3]  = '{1'b1, 1'b0, pk(2'd1, 0, 0, 0, 0, 4'b0000)};
    vecs[4]  = '{1'b0, 1'b0, pk(2'd1, 0, 0, 0, 0, 4'b0000)};
    vecs[5]  = '{1'b0, 1'b1, pk(2'd1, 1, 0, 0, 0, 4'b0000)};
    vecs[6]  = '{1'b0, 1'b0, pk(2'd1, 0, 0, 0, 0, 4'b0000)};
    vecs[7]  = '{1'b1, 1'b0, pk(2'd2, 0, 0, 0, 0, 4'b0000)};
    vecs[8]  = '{1'b0, 1'b0, pk(2'd2, 0, 0, 0, 0, 4'b0000)};
    vecs[9]  = '{1'b0, 1'b1, pk(2'd2, 0, 1, 0, 0, 4'b0000)};
    vecs[10] = '{1'b0, 1'b0, pk(2'd2, 0, 0, 0, 0, 4'b0000)};
    vecs[11] = '{1'b1, 1'b0, pk(2'd0, 0, 0, 1, 1, 4'b0000)};
    vecs[12] = '{1'b0, 1'b0, pk(2'd0, 0, 0, 0, 1, 4'b0000)};

    // Reset and idle in RUN.
    do_reset();
    chk("reset_state", outs, pk(2'd0, 0, 0, 0, 1, 4'b0000));
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("run_idle", outs, pk(2'd0, 0, 0, 0, 1, 4'b0000));
    end

    // Table: mode cycling, single taps, CLR_SECS on exit.
    for (int i = 0; i < 13; i++) begin
      MODE_BTN = vecs[i].mode;
      UP_BTN   = vecs[i].up;
      tick();
      chk($sformatf("vec%0d", i), outs, vecs[i].exp);
    end
    MODE_BTN = 1'b0;
    UP_BTN   = 1'b0;

    // Auto-repeat in SET_MIN.
    do_reset();
    press_mode();
    tick();
    press_mode();
    tick();
    tick();
    chk("rpt_in_set_min", MODE, 2'd2);
    UP_BTN = 1'b1;
    npulse = 0;
    for (int k = 0; k <= 22; k++) begin
      logic e;
      tick();
      e = (k == 0 || k == 10 || k == 13 || k == 16 || k == 19 || k == 22);
      chk($sformatf("rpt_off%0d", k), {INC_HOUR, INC_MIN}, {1'b0, e});
      if (INC_MIN) npulse++;
    end
    chk("rpt_count", npulse, 6);
    UP_BTN = 1'b0;
    nbad = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (INC_MIN || INC_HOUR) nbad++;
    end
    chk("rpt_release_quiet", nbad, 0);

    // Blink in SET_HOUR, UP forces visible, then SET_MIN blink.
    do_reset();
    press_mode();
    chk("blink_h_j0", {MODE, BLANK_MASK}, {2'd1, 4'b0000});
    for (int j = 1; j < 16; j++) begin
      tick();
      em = (((j / 4) % 2) == 1) ? 4'b1100 : 4'b0000;
      chk($sformatf("blink_h_j%0d", j), BLANK_MASK, em);
    end
    UP_BTN = 1'b1;
    tick();
    chk("blink_up_first", {INC_HOUR, BLANK_MASK}, {1'b1, 4'b0000});
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("blink_up_held", BLANK_MASK, 4'b0000);
    end
    UP_BTN = 1'b0;
    press_mode();
    chk("blink_m_j0", {MODE, BLANK_MASK}, {2'd2, 4'b0000});
    for (int j = 1; j < 12; j++) begin
      tick();
      em = (((j / 4) % 2) == 1) ? 4'b0011 : 4'b0000;
      chk($sformatf("blink_m_j%0d", j), BLANK_MASK, em);
    end

    // Simultaneous MODE and UP edge, then timeout.
    do_reset();
    press_mode();
    tick();
    tick();
    MODE_BTN = 1'b1;
    UP_BTN   = 1'b1;
    tick();
    chk("simul_edge", {MODE, INC_HOUR, INC_MIN}, {2'd2, 1'b0, 1'b0});
    MODE_BTN = 1'b0;
    nbad = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (INC_MIN || INC_HOUR) nbad++;
    end
    chk("simul_held_quiet", nbad, 0);
    UP_BTN = 1'b0;
    tick();
    UP_BTN = 1'b1;
    tick();
    chk("simul_repress", {INC_HOUR, INC_MIN}, 2'b01);
    UP_BTN = 1'b0;
    n = -1;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (MODE == 2'd0) begin
        n = k;
        chk("timeout_clr", {CLR_SECS, RUN_EN}, 2'b11);
        break;
      end
    end
    chk("timeout_cycles", n, 49);
    tick();
    chk("timeout_after", outs, pk(2'd0, 0, 0, 0, 1, 4'b0000));

    // Asynchronous reset mid-repeat.
    do_reset();
    press_mode();
    tick();
    tick();
    UP_BTN = 1'b1;
    for (int k = 0; k < 12; k++) tick();
    chk("pre_reset_mode", {MODE, RUN_EN}, {2'd1, 1'b0});
    RESET_N = 1'b0;
    #2;
    chk("async_reset", outs, pk(2'd0, 0, 0, 0, 1, 4'b0000));
    tick();
    tick();
    RESET_N = 1'b1;
    nbad = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (outs !== pk(2'd0, 0, 0, 0, 1, 4'b0000)) nbad++;
    end
    chk("reset_release_quiet", nbad, 0);
    UP_BTN = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
